// File: rtl/mcdt_rr_pkg.sv
// Shared constants, types and width helper for the mcdt_rr block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mcdt_rr_pkg;

  // Width of each per-channel output statistics counter.
  localparam int STAT_W = 16;

  // Default data width; the word type follows it.
  localparam int DEF_DW = 32;

  typedef logic [DEF_DW-1:0] mcdt_word_t;

  // Bits needed to encode values 0..n-1, never less than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mcdt_rr_fifo.sv
// Per-channel synchronous FIFO with occupancy count and free-entry margin.
// Latency: a pushed word is visible at the head the cycle after the push edge.
// Backpressure: push_rdy drops when full (no bypass on same-cycle pop); held low during reset.
module mcdt_rr_fifo
  import mcdt_rr_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 32,
  parameter int MW    = width_of(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [DW-1:0] push_dat,
  input  logic          push_vld,
  output logic          push_rdy,
  input  logic          pop_en,
  output logic [DW-1:0] head_dat,
  output logic          head_vld,
  output logic [MW-1:0] margin
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [MW-1:0] count;
  logic          push;
  logic          pop;

  // Ready and margin come only from the registered count, so a full FIFO
  // stays not-ready even in a cycle where its head is being popped.
  assign push_rdy = !rst_i && (count < MW'(DEPTH));
  assign head_vld = (count != '0);
  assign margin   = MW'(DEPTH) - count;
  assign head_dat = mem[rd_ptr];
  assign push     = push_vld && push_rdy;
  assign pop      = pop_en && head_vld;

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + MW'(push) - MW'(pop);
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/mcdt_rr.sv
// Multi-channel FIFOs drained round-robin into one registered tagged stream; MCDT_RR_STAT_EN adds per-channel output counters.
// Latency: word pushed at edge N can be on mcdt_*_o after edge N+1 (empty FIFO, wins arbitration, output free).
// Backpressure: output register holds while mcdt_ready_i=0; FIFOs then fill and drop ch_ready_o.
module mcdt_rr
  import mcdt_rr_pkg::*;
#(
  parameter int NUM_CH     = 3,
  parameter int DW         = 32,
  parameter int FIFO_DEPTH = 32,
  parameter int MW         = width_of(FIFO_DEPTH + 1),
  parameter int IW         = width_of(NUM_CH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_CH*DW-1:0] ch_data_i,
  input  logic [NUM_CH-1:0]    ch_valid_i,
  output logic [NUM_CH-1:0]    ch_ready_o,
  output logic [NUM_CH*MW-1:0] ch_margin_o,
  output logic [DW-1:0]        mcdt_data_o,
  output logic                 mcdt_val_o,
  output logic [IW-1:0]        mcdt_id_o,
  input  logic                 mcdt_ready_i
`ifdef MCDT_RR_STAT_EN
  ,
  output logic [NUM_CH*STAT_W-1:0] stat_cnt_o
`endif
);

  logic [DW-1:0]     head_dat [NUM_CH];
  logic [NUM_CH-1:0] head_vld;
  logic [NUM_CH-1:0] pop_en;
  logic [IW-1:0]     rr_ptr;
  logic              out_free;
  logic              gnt_any;
  logic [IW-1:0]     gnt_id;
  logic [IW-1:0]     nxt_ptr;
  logic [DW-1:0]     gnt_dat;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    mcdt_rr_fifo #(
      .DW    (DW),
      .DEPTH (FIFO_DEPTH),
      .MW    (MW)
    ) u_fifo (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .push_dat (ch_data_i[k*DW +: DW]),
      .push_vld (ch_valid_i[k]),
      .push_rdy (ch_ready_o[k]),
      .pop_en   (pop_en[k]),
      .head_dat (head_dat[k]),
      .head_vld (head_vld[k]),
      .margin   (ch_margin_o[k*MW +: MW])
    );
  end

  assign out_free = !mcdt_val_o || mcdt_ready_i;

  // Round-robin search from rr_ptr, wrapping; the first non-empty channel wins
  // and is popped only when the output register can take its word.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    nxt_ptr = rr_ptr;
    gnt_dat = '0;
    pop_en  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_CH;
      if (!gnt_any && head_vld[idx]) begin
        gnt_any     = 1'b1;
        gnt_id      = IW'(idx);
        nxt_ptr     = IW'((idx + 1) % NUM_CH);
        gnt_dat     = head_dat[idx];
        pop_en[idx] = out_free;
      end
    end
  end

  // Output register and RR pointer; data/id hold when idle or stalled, pointer moves only on a grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcdt_val_o  <= 1'b0;
      mcdt_data_o <= '0;
      mcdt_id_o   <= '0;
      rr_ptr      <= '0;
    end else if (out_free) begin
      mcdt_val_o <= gnt_any;
      if (gnt_any) begin
        mcdt_data_o <= gnt_dat;
        mcdt_id_o   <= gnt_id;
        rr_ptr      <= nxt_ptr;
      end
    end
  end

`ifdef MCDT_RR_STAT_EN
  for (genvar k = 0; k < NUM_CH; k++) begin : g_stat
    logic [STAT_W-1:0] cnt;

    // Count completed output handshakes from this channel; wraps naturally.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt <= '0;
      end else if (mcdt_val_o && mcdt_ready_i && (mcdt_id_o == IW'(k))) begin
        cnt <= cnt + 1'b1;
      end
    end

    assign stat_cnt_o[k*STAT_W +: STAT_W] = cnt;
  end
`endif

endmodule
